// File: rtl/demux_1_4_stream_pkg.sv
// Shared constants and types for the 1-to-4 stream demultiplexer.
package demux_1_4_stream_pkg;

  localparam int NUM_CH = 4;  // number of output channels
  localparam int SEL_W  = 2;  // width of the channel select
  localparam int CNT_W  = 8;  // width of each delivered-beat counter

  typedef logic [SEL_W-1:0] ch_idx_t;

endpackage : demux_1_4_stream_pkg

// File: rtl/demux_slot.sv
// One output channel: a single-entry slot (full flag plus data register)
// and a wrapping counter of beats delivered to the consumer.
module demux_slot
  import demux_1_4_stream_pkg::*;
#(
  parameter int W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [W-1:0]     wr_data,
  input  logic             ready,
  output logic             valid,
  output logic [W-1:0]     data,
  output logic [CNT_W-1:0] count
);

  logic             full;
  logic             deliver;

  assign deliver = full && ready;
  assign valid   = full;

  // Slot occupancy, payload and delivery counter; a write on the same edge as
  // a delivery refills the slot so the channel sustains one beat per cycle.
  // NOTE: the data register is reset along with the flags so lanes read 0 after reset rather than stale payload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      full  <= 1'b0;
      data  <= '0;
      count <= '0;
    end else begin
      if (wr_en) begin
        full <= 1'b1;
        data <= wr_data;
      end else if (deliver) begin
        full <= 1'b0;
      end
      if (deliver) begin
        count <= count + 1'b1;
      end
    end
  end

endmodule : demux_slot

// File: rtl/demux_1_4_stream.sv
// 1-to-4 valid/ready stream demultiplexer. Each accepted beat is routed to
// the channel named by in_sel, where it waits in a one-entry slot.
module demux_1_4_stream
  import demux_1_4_stream_pkg::*;
#(
  parameter int W = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [W-1:0]            in_data,
  input  ch_idx_t                 in_sel,
  output logic [NUM_CH-1:0]       out_valid,
  input  logic [NUM_CH-1:0]       out_ready,
  output logic [NUM_CH*W-1:0]     out_data,
  output logic [NUM_CH*CNT_W-1:0] out_count
);

  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] wr_en;
  logic              accept;

  // The selected slot can take a beat when empty or when it is being drained
  // this same cycle; independent of in_valid.
  assign in_ready = !full[in_sel] || out_ready[in_sel];
  assign accept   = in_valid && in_ready;
  assign full     = out_valid;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign wr_en[i] = accept && (in_sel == ch_idx_t'(i));

    demux_slot #(.W(W)) u_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_en[i]),
      .wr_data (in_data),
      .ready   (out_ready[i]),
      .valid   (out_valid[i]),
      .data    (out_data[i*W +: W]),
      .count   (out_count[i*CNT_W +: CNT_W])
    );
  end

endmodule : demux_1_4_stream

// File: tb/tb_demux_1_4_stream.sv
// Testbench for demux_1_4_stream: vector table, directed corner sequences
// and random traffic compared against a per-channel occupancy model.
module tb_demux_1_4_stream;

  localparam int W = 4;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_data;
  logic [1:0]  in_sel;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [15:0] out_data;
  logic [31:0] out_count;

  int total = 0;
  int bad   = 0;

  // Reference model: each channel either holds one beat or is empty.
  bit         m_full [4];
  logic [3:0] m_data [4];
  int         m_cnt  [4];

  typedef struct {
    logic        v;
    logic [1:0]  sel;
    logic [3:0]  d;
    logic [3:0]  ordy;
    logic        exp_rdy;
    logic [3:0]  exp_valid;
    logic [15:0] exp_data;
  } vec_t;

  vec_t tbl [7];

  demux_1_4_stream #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_full[i] = 1'b0;
      m_data[i] = '0;
      m_cnt[i]  = 0;
    end
  endtask

  task automatic check_model(input string tag);
    logic [3:0]  ev;
    logic [15:0] ed;
    logic [31:0] ec;
    for (int i = 0; i < 4; i++) begin
      ev[i]          = m_full[i];
      ed[i*4 +: 4]   = m_data[i];
      ec[i*8 +: 8]   = 8'(m_cnt[i] % 256);
    end
    check({tag, "_out_valid"}, {28'd0, out_valid}, {28'd0, ev});
    check({tag, "_out_data"},  {16'd0, out_data},  {16'd0, ed});
    check({tag, "_out_count"}, out_count, ec);
  endtask

  // One clock cycle: drive, check in_ready, advance model at the edge, check outputs.
  task automatic step(input logic v, input logic [1:0] s, input logic [3:0] d,
                      input logic [3:0] ordy, output logic rdy_seen);
    bit exp_rdy;
    bit acc;
    in_valid  = v;
    in_sel    = s;
    in_data   = d;
    out_ready = ordy;
    #1;
    exp_rdy  = !m_full[s] || ordy[s];
    rdy_seen = in_ready;
    check("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    acc = v && exp_rdy;
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      if (m_full[i] && ordy[i]) begin
        m_full[i] = 1'b0;
        m_cnt[i]++;
      end
    end
    if (acc) begin
      m_full[s] = 1'b1;
      m_data[s] = d;
    end
    #1;
    check_model("step");
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    logic rdy;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sel    = 2'd0;
    in_data   = 4'd0;
    out_ready = 4'd0;
    model_reset();

    tbl[0] = '{1'b1, 2'd2, 4'hA, 4'b0000, 1'b1, 4'b0100, 16'h0A00};
    tbl[1] = '{1'b1, 2'd2, 4'h5, 4'b0000, 1'b0, 4'b0100, 16'h0A00};
    tbl[2] = '{1'b1, 2'd1, 4'h3, 4'b0000, 1'b1, 4'b0110, 16'h0A30};
    tbl[3] = '{1'b1, 2'd3, 4'hC, 4'b0000, 1'b1, 4'b1110, 16'hCA30};
    tbl[4] = '{1'b1, 2'd1, 4'h7, 4'b0000, 1'b0, 4'b1110, 16'hCA30};
    tbl[5] = '{1'b1, 2'd1, 4'h7, 4'b0010, 1'b1, 4'b1110, 16'hCA70};
    tbl[6] = '{1'b0, 2'd0, 4'hF, 4'b1111, 1'b1, 4'b0000, 16'hCA70};

    // Post-reset state while rst_n is still low.
    #3;
    check("rst_out_valid", {28'd0, out_valid}, 32'd0);
    check("rst_out_count", out_count, 32'd0);
    check("rst_in_ready",  {31'd0, in_ready}, 32'd1);
    check("rst_out_data",  {16'd0, out_data}, 32'd0);
    #9;
    rst_n = 1'b1;

    // Routing, back-pressure and channel independence vectors; the first
    // row is accepted on the very first edge after reset release.
    for (int k = 0; k < 7; k++) begin
      in_valid  = tbl[k].v;
      in_sel    = tbl[k].sel;
      in_data   = tbl[k].d;
      out_ready = tbl[k].ordy;
      #1;
      check($sformatf("tbl%0d_in_ready", k), {31'd0, in_ready}, {31'd0, tbl[k].exp_rdy});
      step(tbl[k].v, tbl[k].sel, tbl[k].d, tbl[k].ordy, rdy);
      check($sformatf("tbl%0d_out_valid", k), {28'd0, out_valid}, {28'd0, tbl[k].exp_valid});
      check($sformatf("tbl%0d_out_data", k), {16'd0, out_data}, {16'd0, tbl[k].exp_data});
    end
    check("tbl_counts", out_count, 32'h0101_0200);

    // Back-to-back throughput on channel 0.
    do_reset();
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 2'd0, 4'(k), 4'b0001, rdy);
      check($sformatf("tp%0d_in_ready", k), {31'd0, rdy}, 32'd1);
      check($sformatf("tp%0d_lane0", k), {28'd0, out_data[3:0]}, k);
    end
    step(1'b0, 2'd0, 4'd0, 4'b0001, rdy);
    check("tp_count0", {24'd0, out_count[7:0]}, 32'd8);

    // Counter wrap on channel 0 with channel 1 holding a count of 1.
    do_reset();
    step(1'b1, 2'd1, 4'h5, 4'b0000, rdy);
    step(1'b0, 2'd0, 4'h0, 4'b0010, rdy);
    for (int k = 0; k < 256; k++) begin
      step(1'b1, 2'd0, 4'(k), 4'b0001, rdy);
    end
    step(1'b0, 2'd0, 4'd0, 4'b0001, rdy);
    check("wrap_count0", {24'd0, out_count[7:0]}, 32'd0);
    check("wrap_count_hi", {8'd0, out_count[31:8]}, 32'h0000_0001);

    // Random traffic against the model.
    for (int k = 0; k < 400; k++) begin
      step(1'($urandom), 2'($urandom), 4'($urandom), 4'($urandom), rdy);
    end

    // Reset pulse between edges with every slot full.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 2'(k), 4'(k + 9), 4'b0000, rdy);
    end
    step(1'b0, 2'd0, 4'd0, 4'b1000, rdy);
    check("mid_all_full", {28'd0, out_valid}, 32'h0000_0007);
    step(1'b1, 2'd3, 4'h4, 4'b0000, rdy);
    check("mid_all_full2", {28'd0, out_valid}, 32'h0000_000F);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_out_valid", {28'd0, out_valid}, 32'd0);
    check("mid_out_count", out_count, 32'd0);
    check("mid_in_ready", {31'd0, in_ready}, 32'd1);
    #1;
    rst_n = 1'b1;
    model_reset();
    step(1'b0, 2'd0, 4'd0, 4'b1111, rdy);
    check("mid_after_valid", {28'd0, out_valid}, 32'd0);
    check("mid_after_count", out_count, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_demux_1_4_stream

// File: doc/demux_1_4_stream.md
DEMUX_1_4_STREAM -- requirements
Module: demux_1_4_stream

Interface
REQ-001 Parameter W SHALL be: default 4; width of the data payload.
REQ-002 Port clk SHALL be: input, 1 bit; the single clock; all state updates on its rising edge.
REQ-003 Port rst_n SHALL be: input, 1 bit; reset, asynchronous assert, active-low.
REQ-004 Port in_valid SHALL be: input, 1 bit; the upstream beat is present.
REQ-005 Port in_ready SHALL be: output, 1 bit; the block accepts the upstream beat.
REQ-006 Port in_data SHALL be: input, W bits; the upstream payload.
REQ-007 Port in_sel SHALL be: input, 2 bits; the destination channel index, 0..3.
REQ-008 Port out_valid SHALL be: output, 4 bits; bit i means channel i holds a beat.
REQ-009 Port out_ready SHALL be: input, 4 bits; bit i means channel i consumer accepts.
REQ-010 Port out_data SHALL be: output, 4*W bits; channel i payload in bits [i*W +: W].
REQ-011 Port out_count SHALL be: output, 4*8 bits; channel i delivered-beat counter in bits [i*8 +: 8].

Function
REQ-012 The block SHALL accept an upstream beat when in_valid && in_ready are both high at a clock edge.
REQ-013 Each channel SHALL hold exactly one one-entry slot (full flag plus W-bit data register).
REQ-014 in_ready SHALL be combinational and equal to !full[in_sel] || out_ready[in_sel].
REQ-015 in_ready SHALL NOT depend on in_valid.
REQ-016 An accepted beat SHALL be written into slot in_sel, with full set, on the same edge; out_valid[in_sel] rises 1 cycle after acceptance (latency 1).
REQ-017 out_valid[i] SHALL equal full[i], and out_data lane i SHALL equal slot i data; both SHALL be registered, with no combinational path from in_*.
REQ-018 Channel i delivers at an edge where out_valid[i] && out_ready[i] are both high; full[i] clears unless the same edge writes channel i.
REQ-019 On simultaneous delivery and acceptance to the same channel, the slot SHALL take the new data and full[i] SHALL stay 1, giving 1 beat per cycle sustained throughput per channel.
REQ-020 Beats accepted for different channels SHALL never alter other slots, and channels SHALL drain independently in any order.
REQ-021 out_data lane i SHALL stay stable while out_valid[i]=1 and out_ready[i]=0.
REQ-022 out_count lane i SHALL increment by 1 on each delivery on channel i, wrapping 255 -> 0.
REQ-023 When in_valid=0, slots SHALL change only by delivery.
REQ-024 in_sel and in_data SHALL be ignored when in_valid=0.

Reset
REQ-025 While rst_n=0, all full flags, out_valid and out_count SHALL be 0 immediately, without waiting for clk.
REQ-026 While rst_n=0, data registers SHALL reset to 0.
REQ-027 While rst_n=0, in_ready SHALL follow REQ-014 with full=0, so it is 1.
REQ-028 No transfer SHALL be recorded while rst_n=0.
REQ-029 Beats held in slots at reset assertion SHALL be discarded.
REQ-030 The first acceptance SHALL be possible at the first rising clk edge after rst_n deasserts.

Structure
REQ-031 A shared package SHALL define the channel-count constant (4), the select-width constant (2), the counter-width constant (8) and a typedef for the channel index.
REQ-032 The per-channel slot plus counter SHALL be one sub-module, demux_slot, instantiated 4 times through a generate loop.
REQ-033 The top level SHALL contain only the select decode and the in_ready mux.

Verification
REQ-034 The bench SHALL cover post-reset: with rst_n low then high, all out_valid=0, out_count=0, in_ready=1.
REQ-035 The bench SHALL cover single routing: in_sel=2, in_data=4'hA, one cycle, out_ready=0 -> next cycle out_valid=4'b0100, lane 2=4'hA; in_sel=2 again -> in_ready=0.
REQ-036 The bench SHALL cover back-to-back throughput: out_ready=4'b0001, 8 beats to sel 0 (data 0..7) -> in_ready constantly 1, lane 0 shows 0..7 in order, count0=8.
REQ-037 The bench SHALL cover independence: fill ch1 (out_ready=0); beat to sel 3 -> in_ready=1 and ch3 valid while ch1 keeps its data; in_sel=1 stalls until out_ready[1] pulses.
REQ-038 The bench SHALL cover wrap: 256 deliveries on ch0 -> count0 reads 0; ch1-3 counts unchanged.
REQ-039 The bench SHALL cover mid-operation reset: with all slots full, pulse rst_n low between edges -> out_valid=0 immediately, counts 0, no beat delivered afterwards.
